// File: rtl/rr_mux_arbiter_pkg.sv
// Shared arbitration constants and helpers for the round-robin mux arbiter
// and any other arbiter that reuses rr_grant.
package rr_mux_arbiter_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Grant-index width: clog2 of the channel count, never narrower than 1 bit.
    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_grant.sv
// Combinational grant search: rotating priority starting at ptr, or fixed
// priority (lowest index wins) when mode is set.
module rr_grant
    import rr_mux_arbiter_pkg::*;
#(
    parameter int CH   = 4,
    parameter int SELW = sel_width(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    int w_best;
    int w_dist;

    // Each requester gets a distance from the search start; smallest wins.
    always_comb begin
        gnt_idx = '0;
        w_best  = CH;
        w_dist  = 0;
        any     = |req;
        for (int i = 0; i < CH; i++) begin
            w_dist = mode ? i : ((i + CH - int'(ptr)) % CH);
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_idx = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// CH-to-1 valid/ready arbiter with a single registered output stage;
// round-robin or fixed priority selected by MODE.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int CH   = 4,
    parameter int MODE = ARB_RR,
    parameter int SELW = sel_width(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*N-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    output logic [N-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SELW-1:0] w_gnt;
    logic            w_any;
    logic            w_load;
    logic            w_take;
    logic [N-1:0]    w_sel_data;

    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    logic [SELW-1:0] r_out_sel;
    logic [SELW-1:0] r_ptr;

    rr_grant #(
        .CH   (CH),
        .SELW (SELW)
    ) u_grant (
        .req     (in_valid),
        .ptr     (r_ptr),
        .mode    (MODE == ARB_FIXED),
        .gnt_idx (w_gnt),
        .any     (w_any)
    );

    assign w_load = !r_out_valid || out_ready;
    assign w_take = w_load && w_any;

    // One-hot ready and data select from the grant; ready is forced low in reset.
    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_gnt == SELW'(i)) begin
                in_ready[i] = w_take && rst_n;
                w_sel_data  = in_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_sel_data;
                r_out_sel  <= w_gnt;
            end
        end
    end

    // Pointer moves past the winner only on a real input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_take && (MODE == ARB_RR)) begin
            r_ptr <= (w_gnt == SELW'(CH-1)) ? '0 : w_gnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: three instances (CH=4 round-robin, CH=4 fixed,
// CH=3 round-robin) driven by vector tables, directed sequences and random traffic.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic [3:0][31:0] d0, d1;
    logic [2:0][31:0] d2;
    logic [3:0] iv0, iv1, rdy0, rdy1;
    logic [2:0] iv2, rdy2;
    logic or0, or1, or2, ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [1:0] os0, os1, os2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(32), .CH(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(iv0), .in_ready(rdy0),
        .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(or0));

    rr_mux_arbiter #(.N(32), .CH(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(iv1), .in_ready(rdy1),
        .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(or1));

    rr_mux_arbiter #(.N(32), .CH(3), .MODE(0)) u_c3 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(iv2), .in_ready(rdy2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(or2));

    typedef struct {
        int         u;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] rdy;
        logic       v;
        logic [1:0] sel;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    int   cfg_ch[3]   = '{4, 4, 3};
    int   cfg_mode[3] = '{0, 1, 0};
    logic mv[3];
    logic [31:0] md[3];
    int   ms[3];
    int   mp[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic [3:0] v, input logic r);
        case (u)
            0: begin iv0 = v; or0 = r; end
            1: begin iv1 = v; or1 = r; end
            default: begin iv2 = v[2:0]; or2 = r; end
        endcase
    endtask

    function automatic logic [3:0] get_rdy(input int u);
        case (u)
            0: return rdy0;
            1: return rdy1;
            default: return {1'b0, rdy2};
        endcase
    endfunction

    function automatic logic get_valid(input int u);
        case (u)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int u);
        case (u)
            0: return od0;
            1: return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic [1:0] get_sel(input int u);
        case (u)
            0: return os0;
            1: return os1;
            default: return os2;
        endcase
    endfunction

    function automatic logic [31:0] get_in(input int u, input int c);
        case (u)
            0: return d0[c[1:0]];
            1: return d1[c[1:0]];
            default: return d2[c[1:0]];
        endcase
    endfunction

    // Reference grant: walk channels in priority order and take the first requester.
    function automatic int exp_grant(input int ch, input int mode, input int ptr, input logic [3:0] v);
        int c;
        for (int k = 0; k < ch; k++) begin
            c = (mode != 0) ? k : (ptr + k) % ch;
            if (v[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic reset_all();
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) drive(u, 4'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        drive(t.u, t.iv, t.ordy);
        #1;
        chk($sformatf("vec%0d in_ready", idx), {28'b0, get_rdy(t.u)}, {28'b0, t.rdy});
        step();
        chk($sformatf("vec%0d out_valid", idx), {31'b0, get_valid(t.u)}, {31'b0, t.v});
        if (t.v) begin
            chk($sformatf("vec%0d out_sel", idx), {30'b0, get_sel(t.u)}, {30'b0, t.sel});
            chk($sformatf("vec%0d out_data", idx), get_data(t.u), t.data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d0[i] = 32'hA0 + 32'(i);
            d1[i] = 32'hB0 + 32'(i);
        end
        for (int i = 0; i < 3; i++) d2[i] = 32'hC0 + 32'(i);
        reset_all();

        chk("reset out_valid", {31'b0, ov0}, 32'd0);
        chk("reset out_data", od0, 32'd0);
        chk("reset out_sel", {30'b0, os0}, 32'd0);

        // Round-robin rotation, then sparse pulses on channel 1 and channel 0.
        tbl.push_back('{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        tbl.push_back('{0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
        tbl.push_back('{0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2});
        tbl.push_back('{0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3});
        tbl.push_back('{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        tbl.push_back('{0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
        tbl.push_back('{0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        tbl.push_back('{0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0});
        // Fixed priority: channel 1 always beats channel 3.
        tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hB1});
        tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hB1});
        tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hB1});
        tbl.push_back('{1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hB3});
        tbl.push_back('{1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0});
        // CH=3 wrap from 2 back to 0.
        tbl.push_back('{2, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC0});
        tbl.push_back('{2, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hC2});
        tbl.push_back('{2, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC0});
        tbl.push_back('{2, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hC2});
        tbl.push_back('{2, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC0});

        foreach (tbl[i]) apply_vec(tbl[i], i);
        for (int u = 0; u < 3; u++) drive(u, 4'b0, 1'b0);

        // Asynchronous reset while a beat is held under backpressure.
        reset_all();
        drive(0, 4'b0100, 1'b0);
        #1;
        chk("rst pre in_ready", {28'b0, rdy0}, 32'h4);
        step();
        chk("rst pre out_valid", {31'b0, ov0}, 32'd1);
        #1;
        chk("rst held in_ready", {28'b0, rdy0}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", {31'b0, ov0}, 32'd0);
        chk("rst async in_ready", {28'b0, rdy0}, 32'h0);
        chk("rst async out_data", od0, 32'd0);
        step();
        rst_n = 1'b1;
        drive(0, 4'b1111, 1'b1);
        #1;
        chk("rst rewind in_ready", {28'b0, rdy0}, 32'h1);
        step();
        chk("rst rewind out_sel", {30'b0, os0}, 32'd0);
        drive(0, 4'b1000, 1'b1);
        step();
        chk("rst ch3 out_valid", {31'b0, ov0}, 32'd1);
        chk("rst ch3 out_sel", {30'b0, os0}, 32'd3);
        drive(0, 4'b1111, 1'b1);
        step();
        chk("rst wrap out_sel", {30'b0, os0}, 32'd0);

        // Backpressure: channel 2 beat held for five cycles.
        reset_all();
        d0[2] = 32'hDEADBEEF;
        drive(0, 4'b0100, 1'b1);
        step();
        chk("bp load out_sel", {30'b0, os0}, 32'd2);
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b1111, 1'b0);
            #1;
            chk($sformatf("bp%0d in_ready", k), {28'b0, rdy0}, 32'h0);
            step();
            chk($sformatf("bp%0d out_valid", k), {31'b0, ov0}, 32'd1);
            chk($sformatf("bp%0d out_data", k), od0, 32'hDEADBEEF);
            chk($sformatf("bp%0d out_sel", k), {30'b0, os0}, 32'd2);
        end
        drive(0, 4'b1111, 1'b1);
        #1;
        chk("bp release in_ready", {28'b0, rdy0}, 32'h8);
        step();
        chk("bp release out_sel", {30'b0, os0}, 32'd3);
        chk("bp release out_data", od0, 32'hA3);

        // Random traffic on all three instances against the reference model.
        reset_all();
        for (int u = 0; u < 3; u++) begin
            mv[u] = 1'b0; md[u] = '0; ms[u] = 0; mp[u] = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                d0[i] = $urandom;
                d1[i] = $urandom;
            end
            for (int i = 0; i < 3; i++) d2[i] = $urandom;
            for (int u = 0; u < 3; u++)
                drive(u, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            #1;
            for (int u = 0; u < 3; u++) begin
                logic [3:0] v;
                logic       r;
                logic       ld;
                logic [3:0] er;
                int         g;
                case (u)
                    0: begin v = iv0; r = or0; end
                    1: begin v = iv1; r = or1; end
                    default: begin v = {1'b0, iv2}; r = or2; end
                endcase
                g  = exp_grant(cfg_ch[u], cfg_mode[u], mp[u], v);
                ld = !mv[u] || r;
                er = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
                chk($sformatf("rnd u%0d c%0d in_ready", u, cyc), {28'b0, get_rdy(u)}, {28'b0, er});
                if (ld) begin
                    if (g >= 0) begin
                        mv[u] = 1'b1;
                        md[u] = get_in(u, g);
                        ms[u] = g;
                        if (cfg_mode[u] == 0) mp[u] = (g + 1) % cfg_ch[u];
                    end else begin
                        mv[u] = 1'b0;
                    end
                end
            end
            step();
            for (int u = 0; u < 3; u++) begin
                chk($sformatf("rnd u%0d c%0d out_valid", u, cyc), {31'b0, get_valid(u)}, {31'b0, mv[u]});
                if (mv[u]) begin
                    chk($sformatf("rnd u%0d c%0d out_sel", u, cyc), {30'b0, get_sel(u)}, 32'(ms[u]));
                    chk($sformatf("rnd u%0d c%0d out_data", u, cyc), get_data(u), md[u]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
